inv_rotate_unit: RTL and testbench

Decoder-side inverse of the encoder's lane-rotation step: reads 25 state lanes from the shared state memory, rotates each lane right by its fixed per-lane offset (undoing the encoder's left rotation), and writes it back in place. Started from the decoder top-level controller by a `start`/`Ready` handshake. Signals completion with a one-cycle `Done`. Rotation is bit-serial, one position per clock, so per-lane latency depends on the offset.

---
 rtl/inv_rotate_unit.sv | 122 ++++++++++++
 tb/tb_inv_rotate_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_rotate_unit.sv
// inv_rotate_unit: undoes the encoder's lane rotation over the 25-lane state memory.
// Each lane is fetched, rotated right one bit per clock by its fixed offset, then written back in place.
module inv_rotate_unit #(
    parameter int LANE_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              Ready,
    output logic              Done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LANE_W-1:0] mem_rdata,
    output logic [LANE_W-1:0] mem_wdata
);
    typedef enum logic [3:0] {IDLE, INIT, REQ, FETCH, LOADCNT, ROTATE, WRITE, NEXT, FINISH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic [LANE_W-1:0] data_q, data_d;
    logic [5:0]        ofs_raw;
    logic [CNT_W-1:0]  ofs;

    always_comb begin
        ofs_raw = 6'd0;
        case (int'(idx_q))
            1:  ofs_raw = 6'd1;
            2:  ofs_raw = 6'd62;
            3:  ofs_raw = 6'd28;
            4:  ofs_raw = 6'd27;
            5:  ofs_raw = 6'd36;
            6:  ofs_raw = 6'd44;
            7:  ofs_raw = 6'd6;
            8:  ofs_raw = 6'd55;
            9:  ofs_raw = 6'd20;
            10: ofs_raw = 6'd3;
            11: ofs_raw = 6'd10;
            12: ofs_raw = 6'd43;
            13: ofs_raw = 6'd25;
            14: ofs_raw = 6'd39;
            15: ofs_raw = 6'd41;
            16: ofs_raw = 6'd45;
            17: ofs_raw = 6'd15;
            18: ofs_raw = 6'd21;
            19: ofs_raw = 6'd8;
            20: ofs_raw = 6'd18;
            21: ofs_raw = 6'd2;
            22: ofs_raw = 6'd61;
            23: ofs_raw = 6'd56;
            24: ofs_raw = 6'd14;
            default: ofs_raw = 6'd0;
        endcase
    end

    // Offsets reduce mod LANE_W, which for power-of-two widths is a low-bit mask.
    assign ofs = CNT_W'(ofs_raw) & CNT_W'(LANE_W - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rcnt_d  = rcnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT: begin
                idx_d   = '0;
                rcnt_d  = '0;
                data_d  = '0;
                state_d = REQ;
            end
            REQ:     state_d = FETCH;
            FETCH: begin
                data_d  = mem_rdata;
                state_d = LOADCNT;
            end
            LOADCNT: begin
                rcnt_d  = ofs;
                state_d = ROTATE;
            end
            ROTATE: begin
                if (rcnt_q != '0) begin
                    data_d = {data_q[0], data_q[LANE_W-1:1]};
                    rcnt_d = rcnt_q - 1'b1;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = (idx_q == ADDR_W'(24)) ? FINISH : NEXT;
            NEXT: begin
                idx_d   = idx_q + 1'b1;
                state_d = REQ;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rcnt_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rcnt_q  <= rcnt_d;
            data_q  <= data_d;
        end
    end

    assign Ready     = (state_q == IDLE);
    assign Done      = (state_q == FINISH);
    assign mem_read  = (state_q == REQ);
    assign mem_write = (state_q == WRITE);
    assign mem_addr  = idx_q;
    assign mem_wdata = data_q;
endmodule

// File: tb/tb_inv_rotate_unit.sv
// tb_inv_rotate_unit: directed + randomized checks of inv_rotate_unit against a rotate-by-arithmetic model,
// with a 64-bit instance for all timing checks and a 32-bit instance for the narrow-lane round trip.
module tb_inv_rotate_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s64 = 1'b0, s32 = 1'b0;
    logic        ready, done, rd, wr, r32, d32, rd32, wr32;
    logic [4:0]  addr, a32;
    logic [63:0] rdata = '0, wdata;
    logic [31:0] rdata32 = '0, wdata32;
    logic [63:0] mem[25];
    logic [31:0] mem32[25];
    logic        ld = 1'b0;
    logic [4:0]  ld_a = '0;
    logic [63:0] ld_d = '0;
    logic [31:0] ld_d32 = '0;

    int compared = 0, mismatched = 0;
    int ofs[25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
    logic [63:0] orig[25], pre[25], exp_v[25];
    int wq[$];

    always #5 clk = ~clk;

    inv_rotate_unit #(.LANE_W(64), .ADDR_W(5), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(s64), .Ready(ready), .Done(done),
        .mem_read(rd), .mem_write(wr), .mem_addr(addr), .mem_rdata(rdata), .mem_wdata(wdata));

    inv_rotate_unit #(.LANE_W(32), .ADDR_W(5), .CNT_W(6)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(s32), .Ready(r32), .Done(d32),
        .mem_read(rd32), .mem_write(wr32), .mem_addr(a32), .mem_rdata(rdata32), .mem_wdata(wdata32));

    always @(posedge clk) begin
        if (ld) begin
            mem[ld_a]   <= ld_d;
            mem32[ld_a] <= ld_d32;
        end else begin
            if (wr) mem[addr] <= wdata;
            if (rd) rdata <= mem[addr];
            if (wr32) mem32[a32] <= wdata32;
            if (rd32) rdata32 <= mem32[a32];
        end
    end

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
        logic [63:0] m;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((x >> r) | (x << (w - r))) & m;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] x, input int r, input int w);
        return rotr(x, (w - r) % w, w);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [63:0] v[25], input logic [63:0] v32[25]);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            ld = 1'b1; ld_a = 5'(i); ld_d = v[i]; ld_d32 = v32[i][31:0];
        end
        @(negedge clk);
        ld = 1'b0;
    endtask

    // Pulses start for one cycle, then counts busy cycles up to and including Done.
    task automatic run64(input bit pulses, output int cyc);
        bit seen;
        wq.delete();
        s64 = 1'b1;
        @(negedge clk);
        s64 = 1'b0;
        cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            if (!ready) cyc++;
            if (wr) wq.push_back(int'(addr));
            if (done) seen = 1'b1;
            s64 = (pulses && k < 800) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!seen) @(negedge clk);
        end
        s64 = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("done_width", {62'd0, done, ready}, 64'd1);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 25; i++) chk($sformatf("%s_lane%0d", tag, i), mem[i], exp_v[i]);
    endtask

    initial begin
        int cyc, b1, b2, gap, dn, busy;
        logic [63:0] v32[25];
        bit ok;
        #3;
        chk("in_reset", {55'd0, ready, done, rd, wr, addr}, {55'd0, 4'b1000, 5'd0});
        chk("in_reset_wdata", wdata, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), {60'd0, ready, done, rd, wr}, 64'b1000);
        end

        // Single-bit lanes
        for (int i = 0; i < 25; i++) begin pre[i] = {$urandom, $urandom}; v32[i] = '0; end
        pre[0] = 64'hDEADBEEF01234567; pre[1] = 64'd1; pre[2] = 64'd1;
        load(pre, v32);
        run64(1'b0, cyc);
        chk("lane1_bit", mem[1], 64'h8000000000000000);
        chk("lane2_bit", mem[2], 64'h0000000000000004);
        chk("lane0_same", mem[0], 64'hDEADBEEF01234567);
        for (int i = 0; i < 25; i++) exp_v[i] = rotr(pre[i], ofs[i], 64);
        check_mem("single");
        chk("cycles", 64'(cyc), 64'd831);
        chk("wr_count", 64'(wq.size()), 64'd25);
        ok = (wq.size() == 25);
        for (int i = 0; i < wq.size(); i++) if (wq[i] != i) ok = 1'b0;
        chk("wr_order", 64'(ok), 64'd1);

        // Spurious start pulses mid-run must not disturb length or result
        for (int i = 0; i < 25; i++) pre[i] = mem[i];
        run64(1'b1, cyc);
        chk("cycles_pulsed", 64'(cyc), 64'd831);
        for (int i = 0; i < 25; i++) exp_v[i] = rotr(pre[i], ofs[i], 64);
        check_mem("pulsed");

        // Round trip at both lane widths
        for (int i = 0; i < 25; i++) begin
            orig[i] = {$urandom, $urandom};
            pre[i]  = rotl(orig[i], ofs[i] % 64, 64);
            v32[i]  = rotl({32'd0, orig[i][31:0]}, ofs[i] % 32, 32);
        end
        load(pre, v32);
        s64 = 1'b1; s32 = 1'b1;
        @(negedge clk);
        s64 = 1'b0; s32 = 1'b0;
        dn = 0;
        for (int k = 0; k < 2000 && dn != 3; k++) begin
            if (done) dn |= 1;
            if (d32) dn |= 2;
            @(negedge clk);
        end
        chk("rt_both_done", 64'(dn), 64'd3);
        chk("rt32_ready", 64'(r32), 64'd1);
        for (int i = 0; i < 25; i++) exp_v[i] = orig[i];
        check_mem("rt64");
        for (int i = 0; i < 25; i++) chk($sformatf("rt32_lane%0d", i), {32'd0, mem32[i]}, {32'd0, orig[i][31:0]});
        chk("rt32_lane2_ofs30", {32'd0, mem32[2]}, rotr({32'd0, v32[2][31:0]}, 30, 32));

        // Reset during lane 3 rotation
        for (int i = 0; i < 25; i++) pre[i] = {$urandom, $urandom};
        load(pre, v32);
        s64 = 1'b1;
        @(negedge clk);
        s64 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            if (rd && addr == 5'd3) ok = 1'b1;
            else @(negedge clk);
        end
        chk("reach_lane3", 64'(ok), 64'd1);
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset", {55'd0, ready, done, rd, wr, addr}, {55'd0, 4'b1000, 5'd0});
        chk("async_reset_wdata", wdata, 64'd0);
        busy = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || !ready) busy++;
        end
        chk("no_done_after_abort", 64'(busy), 64'd0);
        for (int i = 0; i < 25; i++) exp_v[i] = (i < 3) ? rotr(pre[i], ofs[i], 64) : pre[i];
        check_mem("abort");
        for (int i = 0; i < 25; i++) pre[i] = exp_v[i];
        run64(1'b0, cyc);
        chk("cycles_after_abort", 64'(cyc), 64'd831);
        for (int i = 0; i < 25; i++) exp_v[i] = rotr(pre[i], ofs[i], 64);
        check_mem("rerun");

        // Start held high: back-to-back runs separated by one idle cycle
        s64 = 1'b1;
        b1 = 0; b2 = 0; gap = 0; dn = 0; busy = 0;
        for (int k = 0; k < 3000 && dn < 2; k++) begin
            @(negedge clk);
            if (!ready) busy++;
            else if (dn == 1) gap++;
            if (done) begin
                if (dn == 0) b1 = busy; else b2 = busy;
                dn++;
                busy = 0;
                if (dn == 2) s64 = 1'b0;
            end
        end
        chk("held_run1", 64'(b1), 64'd831);
        chk("held_run2", 64'(b2), 64'd831);
        chk("held_gap", 64'(gap), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("held_stop", {62'd0, ready, done}, 64'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
